switch_debounce: RTL and testbench

//  Conditions raw slide-switch inputs before they drive the board LEDs and other logic.

---
 rtl/switch_debounce_pkg.sv | 27 ++
 rtl/switch_debounce_bit.sv | 94 +++++++++
 rtl/switch_debounce.sv | 68 ++++++
 tb/tb_switch_debounce.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/switch_debounce_pkg.sv
// ---------------------------------------------------------------------------
// switch_debounce_pkg
//   Shared constants for the switch conditioning path.
//   - CLK_FREQ_HZ            : board clock frequency used to turn a debounce
//                              time in milliseconds into a cycle count
//   - DEFAULT_WIDTH          : number of slide switches on the board
//   - DEFAULT_SYNC_STAGES    : synchroniser depth per switch bit
//   - DEFAULT_DEBOUNCE_MS    : how long a new level must be stable
//   - DEFAULT_CNT_MAX        : that stability window expressed in clock cycles
//   - msToCycles()           : helper converting milliseconds to cycles
// ---------------------------------------------------------------------------
package switch_debounce_pkg;

    localparam int CLK_FREQ_HZ         = 50_000_000;
    localparam int DEFAULT_WIDTH       = 8;
    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int DEFAULT_DEBOUNCE_MS = 10;

    // Cycles per millisecond times the requested window; 10 ms at 50 MHz
    // gives 500000.
    function automatic int msToCycles(input int ms);
        return (CLK_FREQ_HZ / 1000) * ms;
    endfunction

    localparam int DEFAULT_CNT_MAX = msToCycles(DEFAULT_DEBOUNCE_MS);

endpackage

// File: rtl/switch_debounce_bit.sv
// ---------------------------------------------------------------------------
// debounce_bit
//   Conditions a single raw switch input: synchronises it into clk, then only
//   accepts a new level once it has differed from the current accepted level
//   for CNT_MAX consecutive cycles.
//   Ports:
//     clk        in   system clock, all state on its rising edge
//     rst_n      in   asynchronous active-low reset
//     switch_i   in   raw asynchronous switch level
//     level_o    out  debounced level (registered)
//     rise_o     out  one-cycle pulse on an accepted 0->1
//     fall_o     out  one-cycle pulse on an accepted 1->0
//     event_o    out  next-state of (rise | fall), so the parent can register
//                     a change flag that lines up with rise_o/fall_o
// ---------------------------------------------------------------------------
module debounce_bit
    import switch_debounce_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int CNT_MAX     = DEFAULT_CNT_MAX
) (
    input  logic clk,
    input  logic rst_n,
    input  logic switch_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic event_o
);

    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    logic [SYNC_STAGES-1:0] syncChain_q;
    logic                   syncLevel;
    logic [CW-1:0]          stableCnt_q, stableCnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    // Plain flop chain into the clock domain; nothing may sit between stages
    // or the metastability settling time is eaten into.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncChain_q <= '0;
        end else begin
            syncChain_q <= {syncChain_q[SYNC_STAGES-2:0], switch_i};
        end
    end

    assign syncLevel = syncChain_q[SYNC_STAGES-1];

    // Count consecutive cycles where the synchronised input disagrees with
    // the accepted level. Any agreement restarts the count, so a bounce
    // shorter than the window never gets through. On the last count the new
    // level is taken and the matching edge pulse fires for one cycle.
    always_comb begin
        stableCnt_d = stableCnt_q;
        level_d     = level_q;
        rise_d      = 1'b0;
        fall_d      = 1'b0;
        if (syncLevel == level_q) begin
            stableCnt_d = '0;
        end else if (stableCnt_q == CNT_LAST) begin
            stableCnt_d = '0;
            level_d     = syncLevel;
            rise_d      = syncLevel;
            fall_d      = ~syncLevel;
        end else begin
            stableCnt_d = stableCnt_q + CW'(1);
        end
    end

    // State and output registers for the counter, level and pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stableCnt_q <= '0;
            level_q     <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
        end else begin
            stableCnt_q <= stableCnt_d;
            level_q     <= level_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign event_o = rise_d | fall_d;

endmodule

// File: rtl/switch_debounce.sv
// ---------------------------------------------------------------------------
// switch_debounce
//   Conditions the raw slide-switch vector before it reaches the LED stage
//   and other logic. Each bit is synchronised and debounced independently
//   by a debounce_bit instance.
//   Ports:
//     clk        in   1      system clock, all state on its rising edge
//     rst_n      in   1      asynchronous active-low reset
//     switch     in   WIDTH  raw asynchronous switch levels
//     sw_db      out  WIDTH  debounced switch levels (registered)
//     sw_rise    out  WIDTH  one-cycle pulse per bit on accepted 0->1
//     sw_fall    out  WIDTH  one-cycle pulse per bit on accepted 1->0
//     sw_change  out  1      one-cycle pulse when any bit rose or fell
// ---------------------------------------------------------------------------
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int CNT_MAX     = DEFAULT_CNT_MAX
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] switch,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_change
);

    logic [WIDTH-1:0] bitEvent;
    logic             swChange_q, swChange_d;

    // One independent conditioner per switch; no ordering between bits.
    for (genvar i = 0; i < WIDTH; i++) begin : gBit
        debounce_bit #(
            .SYNC_STAGES(SYNC_STAGES),
            .CNT_MAX    (CNT_MAX)
        ) uBit (
            .clk     (clk),
            .rst_n   (rst_n),
            .switch_i(switch[i]),
            .level_o (sw_db[i]),
            .rise_o  (sw_rise[i]),
            .fall_o  (sw_fall[i]),
            .event_o (bitEvent[i])
        );
    end

    // The change flag is built from each bit's next-state pulses so that,
    // once registered, it sits in exactly the same cycle as sw_rise/sw_fall.
    // Simultaneous events on several bits collapse into one pulse.
    always_comb begin
        swChange_d = |bitEvent;
    end

    // Register the change flag alongside the per-bit outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swChange_q <= 1'b0;
        end else begin
            swChange_q <= swChange_d;
        end
    end

    assign sw_change = swChange_q;

endmodule

// File: tb/tb_switch_debounce.sv
// ---------------------------------------------------------------------------
// tb_switch_debounce
//   Directed bench for switch_debounce with WIDTH=8, SYNC_STAGES=2, CNT_MAX=4,
//   so an accepted change appears 6 edges after the input step.
// ---------------------------------------------------------------------------
module tb_switch_debounce;

    logic       clk;
    logic       rst_n;
    logic [7:0] switch;
    logic [7:0] sw_db;
    logic [7:0] sw_rise;
    logic [7:0] sw_fall;
    logic       sw_change;

    int errors = 0;
    int checks = 0;
    logic [7:0] curDb;

    typedef struct {
        logic [7:0] sw;
        logic [7:0] expDb;
        logic [7:0] expRise;
        logic [7:0] expFall;
        logic       expChange;
    } vector_t;

    vector_t vecs[$];

    switch_debounce #(
        .WIDTH      (8),
        .SYNC_STAGES(2),
        .CNT_MAX    (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .switch   (switch),
        .sw_db    (sw_db),
        .sw_rise  (sw_rise),
        .sw_fall  (sw_fall),
        .sw_change(sw_change)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one 8-bit quantity and log a FAIL line on disagreement.
    task automatic check8(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, actual, expected, $time);
        end
    endtask

    // Check every output of the DUT against hand-computed values.
    task automatic checkOutput(input string name, input logic [7:0] eDb, input logic [7:0] eRise,
                               input logic [7:0] eFall, input logic eChange);
        check8({name, ".sw_db"}, sw_db, eDb);
        check8({name, ".sw_rise"}, sw_rise, eRise);
        check8({name, ".sw_fall"}, sw_fall, eFall);
        check8({name, ".sw_change"}, {7'b0, sw_change}, {7'b0, eChange});
    endtask

    // Drive the switch vector, then advance past one rising edge and settle.
    task automatic applyStimulus(input logic [7:0] sw);
        switch = sw;
        @(posedge clk);
        #1;
    endtask

    // Step the switches to a new value and follow the 6-edge latency:
    // edges 1-5 keep the old level, edge 6 shows the new level with pulses,
    // edges 7-8 hold the new level with pulses gone.
    task automatic applyStep(input string name, input logic [7:0] newSw, input logic [7:0] newDb,
                             input logic [7:0] eRise, input logic [7:0] eFall);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(newSw);
            if (k < 6)
                checkOutput($sformatf("%s.e%0d", name, k), curDb, 8'h00, 8'h00, 1'b0);
            else if (k == 6)
                checkOutput($sformatf("%s.e%0d", name, k), newDb, eRise, eFall, |(eRise | eFall));
            else
                checkOutput($sformatf("%s.e%0d", name, k), newDb, 8'h00, 8'h00, 1'b0);
        end
        curDb = newDb;
    endtask

    function automatic void addVec(input logic [7:0] sw, input logic [7:0] eDb, input logic [7:0] eRise,
                                   input logic [7:0] eFall, input logic eChange);
        vector_t v;
        v.sw        = sw;
        v.expDb     = eDb;
        v.expRise   = eRise;
        v.expFall   = eFall;
        v.expChange = eChange;
        vecs.push_back(v);
    endfunction

    initial begin
        int riseCount;
        logic [7:0] bouncePattern [8];

        // Single step 0x00 -> 0x01: six edges to acceptance, one-cycle pulse.
        addVec(8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
        addVec(8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
        addVec(8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
        addVec(8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
        addVec(8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
        addVec(8'h01, 8'h01, 8'h01, 8'h00, 1'b1);
        addVec(8'h01, 8'h01, 8'h00, 8'h00, 1'b0);
        // Three-cycle pulse on bit 3 is too short to be accepted.
        addVec(8'h09, 8'h01, 8'h00, 8'h00, 1'b0);
        addVec(8'h09, 8'h01, 8'h00, 8'h00, 1'b0);
        addVec(8'h09, 8'h01, 8'h00, 8'h00, 1'b0);
        for (int k = 0; k < 6; k++)
            addVec(8'h01, 8'h01, 8'h00, 8'h00, 1'b0);

        // Reset held while the switches toggle: everything stays at zero.
        rst_n  = 1'b0;
        switch = 8'h00;
        #1;
        checkOutput("resetAsync", 8'h00, 8'h00, 8'h00, 1'b0);
        applyStimulus(8'hA5);
        applyStimulus(8'h5A);
        applyStimulus(8'hFF);
        checkOutput("resetHeld", 8'h00, 8'h00, 8'h00, 1'b0);
        switch = 8'h00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(8'h00);
            checkOutput($sformatf("releaseIdle.e%0d", k), 8'h00, 8'h00, 8'h00, 1'b0);
        end
        curDb = 8'h00;

        // Table-driven part.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].sw);
            checkOutput($sformatf("vec%0d", i), vecs[i].expDb, vecs[i].expRise,
                        vecs[i].expFall, vecs[i].expChange);
        end
        curDb = 8'h01;

        // Whole-vector steps: all bits together share one change pulse.
        applyStep("clear", 8'h00, 8'h00, 8'h00, 8'h01);
        applyStep("allRise", 8'hFF, 8'hFF, 8'hFF, 8'h00);
        applyStep("upperFall", 8'h0F, 8'h0F, 8'h00, 8'hF0);
        applyStep("lowerFall", 8'h00, 8'h00, 8'h00, 8'h0F);

        // Bit 0 bounces at two-cycle spacing, then holds high.
        bouncePattern = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00};
        for (int k = 0; k < 8; k++) begin
            applyStimulus(bouncePattern[k]);
            checkOutput($sformatf("bounce%0d", k), 8'h00, 8'h00, 8'h00, 1'b0);
        end
        riseCount = 0;
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(8'h01);
            if (sw_rise[0]) riseCount++;
            if (k < 6)
                checkOutput($sformatf("settle.e%0d", k), 8'h00, 8'h00, 8'h00, 1'b0);
            else if (k == 6)
                checkOutput($sformatf("settle.e%0d", k), 8'h01, 8'h01, 8'h00, 1'b1);
            else
                checkOutput($sformatf("settle.e%0d", k), 8'h01, 8'h00, 8'h00, 1'b0);
        end
        check8("bounceRiseCount", 8'(riseCount), 8'd1);
        curDb = 8'h01;

        // Reset in the middle of operation with 0x81 held on the switches.
        applyStep("set81", 8'h81, 8'h81, 8'h80, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midReset", 8'h00, 8'h00, 8'h00, 1'b0);
        applyStimulus(8'h81);
        applyStimulus(8'h81);
        checkOutput("midResetHeld", 8'h00, 8'h00, 8'h00, 1'b0);
        rst_n = 1'b1;
        curDb = 8'h00;
        applyStep("reaccept", 8'h81, 8'h81, 8'h81, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
